execute_cycle: RTL and testbench

//  EX stage of the 5-stage RV32I pipeline; sits between the ID/EX register and the memory stage.
//  - Resolves forwarding on both operands, runs the ALU, and computes the branch target and decision.
//  - Registers all results into the EX/MEM pipeline register that drives the memory stage.
//  - Optional iterative multiplier (MUL) holds the pipeline while it computes.

---
 rtl/execute_cycle.sv | 188 ++++++++++++++++++
 tb/tb_execute_cycle.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (ALUControlE 111).
module execute_cycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             ALUSrcE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             BranchE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] Imm_Ext_E,
  input  logic [4:0]       RD_E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             StallE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic [4:0]       RD_M,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ALU_ResultM
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [WIDTH-1:0] src_a, rd2f, src_b;
  logic [WIDTH-1:0] alu_res, ex_res;
  logic             stall;

  logic             rw_q, mw_q, rs_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] pcp4_q, wd_q, alu_q;

  always_comb begin
    unique case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    unique case (ForwardB_E)
      2'b01:   rd2f = ResultW;
      2'b10:   rd2f = ALU_ResultM;
      default: rd2f = RD2_E;
    endcase
  end

  assign src_b     = ALUSrcE ? Imm_Ext_E : rd2f;
  assign PCSrcE    = BranchE & (src_a == rd2f);
  assign PCTargetE = PCE + Imm_Ext_E;

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(src_a) < $signed(src_b)};
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mstate_t;

  mstate_t          state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The trigger cycle performs the first step, so BUSY runs WIDTH-1
  // steps and the whole multiply still spans WIDTH stall cycles.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ALUControlE == OP_MUL) begin
          stall    = 1'b1;
          acc_d    = src_b[0] ? src_a : '0;
          mcand_d  = src_a << 1;
          mplier_d = src_b >> 1;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        stall    = 1'b1;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_res = (state_q == S_DONE) ? acc_q : alu_res;
`else
  assign stall  = 1'b0;
  assign ex_res = alu_res;
`endif

  assign StallE = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q   <= 1'b0;
      mw_q   <= 1'b0;
      rs_q   <= 1'b0;
      rd_q   <= '0;
      pcp4_q <= '0;
      wd_q   <= '0;
      alu_q  <= '0;
    end else if (stall) begin
      rw_q   <= 1'b0;
      mw_q   <= 1'b0;
      rs_q   <= 1'b0;
      rd_q   <= '0;
      pcp4_q <= '0;
      wd_q   <= '0;
      alu_q  <= '0;
    end else begin
      rw_q   <= RegWriteE;
      mw_q   <= MemWriteE;
      rs_q   <= ResultSrcE;
      rd_q   <= RD_E;
      pcp4_q <= PCPlus4E;
      wd_q   <= rd2f;
      alu_q  <= ex_res;
    end
  end

  assign RegWriteM   = rw_q;
  assign MemWriteM   = mw_q;
  assign ResultSrcM  = rs_q;
  assign RD_M        = rd_q;
  assign PCPlus4M    = pcp4_q;
  assign WriteDataM  = wd_q;
  assign ALU_ResultM = alu_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: vector table, hand sequences and a random run
// against an arithmetic reference model.
module tb_execute_cycle;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]   ALUControlE;
  logic [W-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]   RD_E;
  logic [1:0]   ForwardA_E, ForwardB_E;
  logic         PCSrcE, StallE, RegWriteM, MemWriteM, ResultSrcM;
  logic [W-1:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [4:0]   RD_M;

  execute_cycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic         alusrc, br;
    logic [1:0]   fa, fb;
    logic [W-1:0] rd1, rd2, imm, pc, resw;
    logic         rw, mw, rs;
    logic [4:0]   rd;
    logic [W-1:0] pcp4;
    logic [W-1:0] exp_alu, exp_wd;
    logic         exp_pcsrc;
    logic [W-1:0] exp_tgt;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_alu = '0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] op, input logic alusrc, input logic br,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [W-1:0] rd1, input logic [W-1:0] rd2,
    input logic [W-1:0] imm, input logic [W-1:0] pc,
    input logic [W-1:0] resw, input logic [W-1:0] ea,
    input logic [W-1:0] ew, input logic ep, input logic [W-1:0] et);
    vec_t v;
    v.op = op; v.alusrc = alusrc; v.br = br; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc; v.resw = resw;
    v.rw = 1'($urandom); v.mw = 1'($urandom); v.rs = 1'($urandom);
    v.rd = 5'($urandom); v.pcp4 = $urandom;
    v.exp_alu = ea; v.exp_wd = ew; v.exp_pcsrc = ep; v.exp_tgt = et;
    return v;
  endfunction

  function automatic logic [W-1:0] fwd(input logic [1:0] c,
    input logic [W-1:0] rf, input logic [W-1:0] rw,
    input logic [W-1:0] am);
    if (c == 2'b01) return rw;
    if (c == 2'b10) return am;
    return rf;
  endfunction

  // Reference model: plain arithmetic on the operand values.
  function automatic vec_t model(input vec_t v);
    logic [W-1:0]   a, d2, b;
    logic [2*W-1:0] p;
    a  = fwd(v.fa, v.rd1, v.resw, prev_alu);
    d2 = fwd(v.fb, v.rd2, v.resw, prev_alu);
    b  = v.alusrc ? v.imm : d2;
    p  = 64'(a) * 64'(b);
    case (v.op)
      3'd0: v.exp_alu = a + b;
      3'd1: v.exp_alu = a - b;
      3'd2: v.exp_alu = a & b;
      3'd3: v.exp_alu = a | b;
      3'd5: v.exp_alu = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd7: v.exp_alu = MUL_EN ? p[W-1:0] : '0;
      default: v.exp_alu = '0;
    endcase
    v.exp_wd    = d2;
    v.exp_pcsrc = v.br && (a == d2);
    v.exp_tgt   = v.pc + v.imm;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ALUControlE = v.op; ALUSrcE = v.alusrc; BranchE = v.br;
    ForwardA_E = v.fa; ForwardB_E = v.fb;
    RD1_E = v.rd1; RD2_E = v.rd2; Imm_Ext_E = v.imm;
    PCE = v.pc; ResultW = v.resw;
    RegWriteE = v.rw; MemWriteE = v.mw; ResultSrcE = v.rs;
    RD_E = v.rd; PCPlus4E = v.pcp4;
  endtask

  // Called #1 after a rising edge; returns #1 after the capturing edge.
  task automatic run(input vec_t v, input string nm);
    bit mulop;
    mulop = MUL_EN && (v.op == 3'd7);
    drive(v);
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      chk({nm, ".pcsrc"}, W'(PCSrcE), W'(v.exp_pcsrc));
      chk({nm, ".tgt"}, PCTargetE, v.exp_tgt);
      if (mulop && k < W) begin
        chk({nm, ".stall"}, W'(StallE), 1);
        @(posedge clk); #1;
        chk({nm, ".bubble_rw"}, W'(RegWriteM), 0);
        chk({nm, ".bubble_mw"}, W'(MemWriteM), 0);
        chk({nm, ".bubble_alu"}, ALU_ResultM, 0);
      end else begin
        chk({nm, ".stall"}, W'(StallE), 0);
        @(posedge clk); #1;
        chk({nm, ".alu"}, ALU_ResultM, v.exp_alu);
        chk({nm, ".wd"}, WriteDataM, v.exp_wd);
        chk({nm, ".rw"}, W'(RegWriteM), W'(v.rw));
        chk({nm, ".mw"}, W'(MemWriteM), W'(v.mw));
        chk({nm, ".rs"}, W'(ResultSrcM), W'(v.rs));
        chk({nm, ".rd"}, W'(RD_M), W'(v.rd));
        chk({nm, ".pcp4"}, PCPlus4M, v.pcp4);
        prev_alu = v.exp_alu;
        break;
      end
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".stall"}, W'(StallE), 0);
    chk({nm, ".rw"}, W'(RegWriteM), 0);
    chk({nm, ".mw"}, W'(MemWriteM), 0);
    chk({nm, ".rs"}, W'(ResultSrcM), 0);
    chk({nm, ".rd"}, W'(RD_M), 0);
    chk({nm, ".pcp4"}, PCPlus4M, 0);
    chk({nm, ".wd"}, WriteDataM, 0);
    chk({nm, ".alu"}, ALU_ResultM, 0);
  endtask

  function automatic logic [W-1:0] edge_val();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return 1;
      2: return '1;
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[$];
  vec_t v;
  logic [2:0] ops[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    tbl.push_back(mk(0,0,0,0,0, 5, 7, 0, 0, 0, 12, 7, 0, 0));
    tbl.push_back(mk(1,0,0,0,0, 3, 5, 0, 0, 0, 32'hFFFFFFFE, 5, 0, 0));
    tbl.push_back(mk(2,0,0,0,0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0,
                     32'hF000F000, 32'hFF00FF00, 0, 0));
    tbl.push_back(mk(3,0,0,0,0, 32'h0F00, 32'h00F0, 0, 0, 0,
                     32'h0FF0, 32'h00F0, 0, 0));
    tbl.push_back(mk(5,0,0,0,0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(5,0,0,0,0, 1, 32'hFFFFFFFF, 0, 0, 0,
                     0, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(4,0,0,0,0, 1, 2, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(6,0,0,0,0, 1, 2, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0,1,0,0,0, 16, 99, 32'hFFFFFFF0, 0, 0,
                     0, 99, 0, 32'hFFFFFFF0));
    tbl.push_back(mk(0,0,0,1,0, 32'hDEAD, 1, 0, 0, 32'h1000,
                     32'h1001, 1, 0, 0));
    tbl.push_back(mk(0,0,0,3,3, 4, 9, 0, 0, 32'h77, 13, 9, 0, 0));
    tbl.push_back(mk(1,0,0,0,1, 6, 32'h55, 0, 0, 2, 4, 2, 0, 0));
    tbl.push_back(mk(1,0,1,0,0, 32'h10, 32'h10, 32'h20, 32'h100, 0,
                     0, 32'h10, 1, 32'h120));
    tbl.push_back(mk(1,0,1,0,0, 32'h10, 32'h11, 32'h20, 32'h100, 0,
                     32'hFFFFFFFF, 32'h11, 0, 32'h120));
    tbl.push_back(mk(0,1,1,0,0, 32'h10, 32'h11, 32'h10, 32'h100, 0,
                     32'h20, 32'h11, 0, 32'h110));
    tbl.push_back(mk(0,1,1,0,0, 32'h10, 32'h10, 32'h20, 32'hFFFFFFF0, 0,
                     32'h30, 32'h10, 1, 32'h10));
    tbl.push_back(mk(0,0,0,0,0, 3, 3, 0, 0, 0, 6, 3, 0, 0));

    rst = 1'b1;
    drive(mk(0,0,0,0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk_reset("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    run(mk(0,0,0,0,0, 2, 3, 0, 0, 0, 5, 3, 0, 0), "fwd_pre");
    run(mk(0,0,0,2,0, 32'hDEAD, 7, 0, 0, 0, 12, 7, 0, 0), "fwdA_M");
    run(mk(0,0,0,0,2, 1, 32'hBEEF, 0, 0, 0, 13, 12, 0, 0), "fwdB_M");

`ifdef EXEC_MUL_EN
    run(mk(7,0,0,0,0, 32'h00010003, 32'h00020005, 0, 0, 0,
           32'h000B000F, 32'h00020005, 0, 0), "mul");
    run(mk(7,0,0,0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0,
           1, 32'hFFFFFFFF, 0, 0), "mul_ones");
    run(mk(7,0,0,0,0, 32'hFFFFFFFF, 5, 0, 0, 0,
           32'hFFFFFFFB, 5, 0, 0), "mul_neg");
    run(mk(7,0,0,0,0, 0, 32'h1234, 0, 0, 0, 0, 32'h1234, 0, 0), "mul_zero");
    run(mk(7,1,0,0,0, 32'h1234, 9, 1, 0, 0, 32'h1234, 9, 0, 1), "mul_one");

    v = mk(7,0,0,0,0, 6, 7, 0, 0, 0, 0, 0, 0, 0);
    v.rw = 1'b1;
    drive(v);
    repeat (5) @(posedge clk);
    #1;
    chk("abort.stall_before", W'(StallE), 1);
    #2 rst = 1'b1;
    #1;
    chk_reset("abort");
    ALUControlE = 3'd0;
    @(negedge clk); rst = 1'b0;
    prev_alu = '0;
    @(posedge clk); #1;
    run(mk(0,0,0,0,0, 6, 7, 0, 0, 0, 13, 7, 0, 0), "after_abort");
`else
    run(mk(7,0,0,0,0, 3, 4, 0, 0, 0, 0, 4, 0, 0), "op7_nomul");
`endif

    run(mk(0,0,0,0,0, 40, 2, 0, 0, 0, 42, 2, 0, 0), "pre_reset");
    #2 rst = 1'b1;
    #1;
    chk_reset("midreset");
    @(negedge clk); rst = 1'b0;
    prev_alu = '0;
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      v = mk(ops[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
             2'($urandom), 2'($urandom), edge_val(), edge_val(),
             edge_val(), $urandom, $urandom, 0, 0, 0, 0);
      if (($urandom_range(0, 3) == 0) && v.br) v.rd2 = v.rd1;
      if (v.op == 3'd7) begin
        if (v.fa == 2'b10) v.fa = 2'b00;
        if (v.fb == 2'b10) v.fb = 2'b11;
      end
      v = model(v);
      run(v, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
